// File: rtl/ram_fifo_ctrl_4bit_pkg.sv
// Shared sizing for the show-ahead FIFO controller and the RAM-side blocks around it.
package ram_fifo_ctrl_4bit_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int ADDR_WIDTH_DEF = 7;
    localparam int AF_LEVEL_DEF   = 120;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int DEPTH_DEF   = depth_of(ADDR_WIDTH_DEF);
    localparam int COUNT_WIDTH = ADDR_WIDTH_DEF + 1;

endpackage

// File: rtl/ram_fifo_ctrl_4bit_if.sv
// Producer and consumer valid/ready streams of the FIFO controller.
interface ram_fifo_ctrl_4bit_if
    import ram_fifo_ctrl_4bit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    // Environment side: produces words in, consumes the head.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Controller side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/ram_fifo_ctrl_4bit.sv
// Show-ahead FIFO controller driving an external single-clock RAM whose read address is registered.
module ram_fifo_ctrl_4bit
    import ram_fifo_ctrl_4bit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AF_LEVEL   = AF_LEVEL_DEF
) (
    input  logic                  clk,
    input  logic                  async_clear_n,
    input  logic                  flush,
    ram_fifo_ctrl_4bit_if.slave   strm,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  ram_we,
    output logic                  ram_clear,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full
);
    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  push;
    logic                  pop;

    assign strm.in_ready  = !full && !flush && !ram_clear;
    assign strm.out_valid = !empty && !ram_clear;
    assign strm.out_data  = ram_q;

    assign push = strm.in_valid && strm.in_ready;
    assign pop  = strm.out_valid && strm.out_ready;

    assign ram_we         = push;
    assign ram_write_addr = wr_ptr;
    assign ram_data       = strm.in_data;

    // The RAM registers this address, so presenting the next head keeps its copy equal to rd_ptr.
    // A flush parks it at 0 to match the pointer reset even if a pop is requested alongside.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ram_read_addr = rd_ptr;
        if (flush)
            ram_read_addr = '0;
        else if (pop)
            ram_read_addr = rd_ptr + ADDR_WIDTH'(1);
    end

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge async_clear_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!async_clear_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            ram_clear   <= 1'b1;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            ram_clear   <= 1'b1;
        end else begin
            wr_ptr      <= wr_ptr + ADDR_WIDTH'(push);
            rd_ptr      <= rd_ptr + ADDR_WIDTH'(pop);
            count       <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == CNT_W'(DEPTH));
            almost_full <= (count_next >= CNT_W'(AF_LEVEL));
            ram_clear   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl_4bit.sv
// Bench for ram_fifo_ctrl_4bit with an attached 128x4 RAM model and a queue-based reference FIFO.
module tb_ram_fifo_ctrl_4bit;
    import ram_fifo_ctrl_4bit_pkg::*;

    logic clk = 1'b0;
    logic async_clear_n = 1'b1;
    logic flush = 1'b0;
    logic [3:0] ram_data, ram_q;
    logic [6:0] ram_write_addr, ram_read_addr;
    logic ram_we, ram_clear;
    logic [COUNT_WIDTH-1:0] count;
    logic empty, full, almost_full;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    ram_fifo_ctrl_4bit_if #(.DATA_WIDTH(4)) strm ();

    ram_fifo_ctrl_4bit dut (
        .clk            (clk),
        .async_clear_n  (async_clear_n),
        .flush          (flush),
        .strm           (strm),
        .ram_data       (ram_data),
        .ram_write_addr (ram_write_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_we         (ram_we),
        .ram_clear      (ram_clear),
        .ram_q          (ram_q),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full)
    );

    always #5 clk = ~clk;

    // RAM: write on clk, registered read address, combinational q, async active-high clear.
    logic [3:0] mem [128];
    logic [6:0] raddr_q;
    always @(posedge clk or posedge ram_clear) begin
        if (ram_clear) begin
            for (int i = 0; i < 128; i++) mem[i] <= 4'h0;
        end else if (ram_we) begin
            mem[ram_write_addr] <= ram_data;
        end
    end
    always @(posedge clk) raddr_q <= ram_read_addr;
    assign ram_q = mem[raddr_q];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference FIFO: a queue of words plus the one-cycle clearing window after reset/flush.
    logic [3:0] mq [$];
    logic m_clr = 1'b1;
    bit m_rdy, m_vld;
    always @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n) begin
            mq.delete();
            m_clr <= 1'b1;
        end else begin
            m_rdy = (mq.size() < 128) && !flush && !m_clr;
            m_vld = (mq.size() > 0) && !m_clr;
            if (flush) begin
                mq.delete();
                m_clr <= 1'b1;
            end else begin
                m_clr <= 1'b0;
                if (m_vld && strm.out_ready) void'(mq.pop_front());
                if (m_rdy && strm.in_valid) mq.push_back(strm.in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_rdy, e_vld;
            e_rdy = (mq.size() < 128) && !flush && !m_clr;
            e_vld = (mq.size() > 0) && !m_clr;
            check("in_ready", 32'(strm.in_ready), 32'(e_rdy));
            check("out_valid", 32'(strm.out_valid), 32'(e_vld));
            check("count", 32'(count), 32'(mq.size()));
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("full", 32'(full), 32'(mq.size() == 128));
            check("almost_full", 32'(almost_full), 32'(mq.size() >= 120));
            check("ram_clear", 32'(ram_clear), 32'(m_clr));
            check("ram_we", 32'(ram_we), 32'(strm.in_valid && e_rdy));
            if (e_vld) check("out_data", 32'(strm.out_data), 32'(mq[0]));
        end
    end

    task automatic drive(input bit fl, input bit iv, input logic [3:0] d, input bit ordy);
        flush          = fl;
        strm.in_valid  = iv;
        strm.in_data   = d;
        strm.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_clear", 32'(ram_clear), 32'd1);
        check("rst_in_ready", 32'(strm.in_ready), 32'd0);
        check("rst_out_valid", 32'(strm.out_valid), 32'd0);
    endtask

    initial begin
        strm.in_valid  = 1'b0;
        strm.in_data   = 4'h0;
        strm.out_ready = 1'b0;
        #2 async_clear_n = 1'b0;
        chk_en = 1'b1;
        #1 check_reset_state();
        repeat (2) @(posedge clk);
        #1 async_clear_n = 1'b1;
        check("clear_until_edge", 32'(ram_clear), 32'd1);

        // First edge after release only drops ram_clear; the second accepts 0x3.
        drive(0, 1, 4'h3, 0);
        check("clear_dropped", 32'(ram_clear), 32'd0);
        check("no_push_in_clear", 32'(count), 32'd0);
        drive(0, 1, 4'h3, 0);
        check("first_valid", 32'(strm.out_valid), 32'd1);
        check("first_data", 32'(strm.out_data), 32'h3);
        check("first_count", 32'(count), 32'd1);
        drive(0, 0, 4'h0, 1);

        // Fill to full; almost_full must first appear at count 120.
        for (int i = 0; i < 128; i++) begin
            drive(0, 1, 4'(i), 0);
            if (i == 118) check("af_below", 32'(almost_full), 32'd0);
            if (i == 119) check("af_at_120", 32'(almost_full), 32'd1);
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd128);
        check("full_in_ready", 32'(strm.in_ready), 32'd0);
        drive(0, 1, 4'hF, 0);
        check("full_no_accept", 32'(count), 32'd128);

        // Drain in order across the pointer wrap.
        for (int i = 0; i < 128; i++) begin
            check("drain_data", 32'(strm.out_data), 32'(i % 16));
            drive(0, 0, 4'h0, 1);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // count=1 with simultaneous push and pop.
        drive(0, 1, 4'hA, 0);
        check("head_a", 32'(strm.out_data), 32'hA);
        drive(0, 1, 4'h5, 1);
        check("pushpop_data", 32'(strm.out_data), 32'h5);
        check("pushpop_count", 32'(count), 32'd1);
        drive(0, 0, 4'h0, 1);

        // Flush wins over concurrent push and pop.
        for (int i = 0; i < 10; i++) drive(0, 1, 4'(i + 3), 0);
        check("pre_flush_count", 32'(count), 32'd10);
        drive(1, 1, 4'hE, 1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_clear", 32'(ram_clear), 32'd1);
        check("flush_valid", 32'(strm.out_valid), 32'd0);
        drive(0, 1, 4'h7, 0);
        check("flush_clear_once", 32'(ram_clear), 32'd0);
        check("flush_no_accept", 32'(count), 32'd0);
        drive(0, 1, 4'h7, 0);
        check("post_flush_data", 32'(strm.out_data), 32'h7);
        drive(1, 0, 4'h0, 0);
        drive(1, 0, 4'h0, 0);
        check("flush_b2b_clear", 32'(ram_clear), 32'd1);
        drive(0, 0, 4'h0, 0);
        check("flush_b2b_end", 32'(ram_clear), 32'd0);

        // Random traffic with a mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            int ph;
            ph = (i / 75) % 4;
            if (i == 300) begin
                #2 async_clear_n = 1'b0;
                #1 check_reset_state();
                repeat (2) @(posedge clk);
                #1 async_clear_n = 1'b1;
            end
            drive(($urandom % 40) == 0,
                  ($urandom % 100) < ((ph == 0) ? 85 : (ph == 2) ? 20 : 55),
                  4'($urandom),
                  ($urandom % 100) < ((ph == 0) ? 15 : (ph == 2) ? 90 : 50));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl_4bit.md
Name: ram_fifo_ctrl_4bit

Overview:
- Show-ahead FIFO controller wrapped around the existing 128x4 single-clock RAM.
- RAM write address is written directly; RAM read address is registered inside the RAM, so q tracks the registered address combinationally.
- This block sits directly upstream of the RAM. It turns a valid/ready producer stream into RAM writes, and RAM q into a valid/ready consumer stream.
- It owns the pointers, the occupancy count, the flush sequencing, and the RAM async_clear drive.

Parameters:
- DATA_WIDTH, 4, word width; must equal the RAM data width.
- ADDR_WIDTH, 7, RAM address width; DEPTH = 2**ADDR_WIDTH = 128.
- AF_LEVEL, 120, almost_full asserts when count >= AF_LEVEL.

Ports:
- clk  in  1  single clock, rising edge.
- async_clear_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all contents.
- in_data  in  DATA_WIDTH  producer word.
- in_valid  in  1  producer word present.
- in_ready  out  1  controller accepts word this cycle.
- out_data  out  DATA_WIDTH  head word (equal to ram_q).
- out_valid  out  1  head word present.
- out_ready  in  1  consumer takes head this cycle.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_write_addr  out  ADDR_WIDTH  to RAM write_addr.
- ram_read_addr  out  ADDR_WIDTH  to RAM read_addr.
- ram_we  out  1  to RAM we.
- ram_clear  out  1  to RAM async_clear (active high).
- ram_q  in  DATA_WIDTH  from RAM q.
- count  out  ADDR_WIDTH+1  occupancy, 0..128.
- empty, full, almost_full  out  1  status flags.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on async_clear_n.
  - While async_clear_n=0: wr_ptr=0, rd_ptr=0, count=0, ram_clear=1.
  - Outputs under reset: empty=1, full=0, almost_full=0, out_valid=0, in_ready=0.
  - ram_clear deasserts on the first clk edge after release, so the RAM is zeroed throughout reset.
- Handshake rules:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = !full & !flush & !ram_clear (combinational).
  - out_valid = !empty & !ram_clear; out_data = ram_q.
- RAM drive:
  - ram_we = push; ram_write_addr = wr_ptr; ram_data = in_data.
  - ram_read_addr = pop ? rd_ptr+1 : rd_ptr (combinational next head). This keeps the RAM's registered address equal to rd_ptr, so the head is visible with zero added latency.
- Clock edge update:
  - wr_ptr += push; rd_ptr += pop.
  - count += push - pop; simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH (127 -> 0), with no special case.
- Flags are registered from next count: empty = (count==0); full = (count==DEPTH); almost_full = (count>=AF_LEVEL).
- Latency: a word pushed at edge N is on out_data with out_valid=1 after edge N. This holds including when the FIFO was empty, because the RAM write and the count update share the same edge.
- Full: in_ready=0. Push and pop in the same cycle is not possible while full; pop alone makes room next cycle.
- Empty: out_valid=0, so no pop. Push alone gives count=1 next cycle.
- count=1 with push and pop together: the read address advances onto the word being written. The new word is head after the edge.
- Flush:
  - Flush wins over push and pop. At the edge with flush=1, pointers and count go to 0 and ram_clear goes to 1 for exactly one cycle.
  - During that cycle the RAM is asynchronously zeroed and in_ready=0, out_valid=0.
  - Back-to-back flush holds ram_clear high.
- Reset mid-operation: all state is lost immediately; no partial writes are guaranteed.
- in_valid while in_ready=0: the word is held by the producer and is not an error.

Decomposition:
- Shared package holds:
  - DATA_WIDTH/ADDR_WIDTH defaults;
  - the DEPTH derivation;
  - a count-width constant (ADDR_WIDTH+1) reused by the RAM-side blocks.
- No sub-module: the pointer/count logic is small.
- The RAM is instantiated by the parent, not inside this block, so the RAM can be shared with test access.

Test Plan:
- Reset release, then push 0x3 -> next cycle out_valid=1, out_data=0x3, count=1, ram_clear was 1 only until the first edge.
- Push 128 words 0x0..0xF repeating with out_ready=0 -> full=1 at count=128, in_ready=0, almost_full first seen at count=120.
- From full, pop 128 with in_valid=0 -> data in order, wrap 127->0 correct, empty=1 at end.
- count=1 (head 0xA), push 0x5 with out_ready=1 -> next cycle out_data=0x5, count=1.
- Fill to 10, assert flush with simultaneous push and pop -> next cycle count=0, ram_clear=1 for one cycle, no word accepted; following push of 0x7 reads back 0x7.
- Drive async_clear_n low mid-stream with random push/pop -> all flags reset immediately; after release the first pushed word is the first popped.
